// File: rtl/led_frame_sequencer_pkg.sv
// led_frame_sequencer_pkg
//   Shared types and helpers for the LED frame sequencer.
//   seq_state_t    : frame controller states
//   CHANNEL_WIDTH  : width of one colour channel inside a pixel word
//   MAX_DATA_WIDTH : widest pixel word bit_reverse can handle
//   bit_reverse    : full-width bit mirror; callers left-align narrower
//                    words so the mirrored word lands in the low bits
package led_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SEND,
        DRAIN_HANDOVER,
        DRAIN_LATCH
    } seq_state_t;

    localparam int unsigned CHANNEL_WIDTH  = 8;
    localparam int unsigned MAX_DATA_WIDTH = 64;

    function automatic logic [MAX_DATA_WIDTH-1:0] bit_reverse(
        input logic [MAX_DATA_WIDTH-1:0] value
    );
        logic [MAX_DATA_WIDTH-1:0] mirrored;
        mirrored = '0;
        for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
            mirrored[i] = value[MAX_DATA_WIDTH-1-i];
        end
        return mirrored;
    endfunction

endpackage

// File: rtl/led_frame_sequencer_pixel_scaler.sv
// pixel_scaler
//   Global brightness stage: every whole CHANNEL_WIDTH field of the pixel
//   becomes (field * (brightness + 1)) >> 8; leftover high bits pass through.
//   One register stage; only instantiated when LED_SEQ_BRIGHTNESS_EN is set.
// Ports
//   clock, reset_n : clock, synchronous active-low reset
//   load           : capture and scale pixel this cycle
//   pixel          : raw pixel word
//   brightness     : global scale, 255 is identity
//   scaled         : scaled word, held until the next load
//   valid          : one-cycle pulse, the cycle after load
module pixel_scaler
    import led_frame_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] pixel,
    input  logic [7:0]            brightness,
    output logic [DATA_WIDTH-1:0] scaled,
    output logic                  valid
);

    localparam int unsigned NUM_FIELDS = DATA_WIDTH / CHANNEL_WIDTH;

    logic [DATA_WIDTH-1:0] scaled_next;
    logic [15:0]           product;

    always_comb begin
        scaled_next = pixel;
        product     = '0;
        for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
            product = 16'(pixel[f*CHANNEL_WIDTH +: CHANNEL_WIDTH]) * (16'(brightness) + 16'd1);
            scaled_next[f*CHANNEL_WIDTH +: CHANNEL_WIDTH] = CHANNEL_WIDTH'(product >> 8);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scaled <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= load;
            if (load) begin
                scaled <= scaled_next;
            end
        end
    end

endmodule

// File: rtl/led_frame_sequencer.sv
// led_frame_sequencer
//   Reads NUM_LEDS pixel words from a 1-cycle-latency frame buffer and hands
//   them back-to-back to a unipolar_rz encoder, then waits out the encoder's
//   latch interval before pulsing done.
//   Optional feature macro: LED_SEQ_BRIGHTNESS_EN (adds brightness port and
//   a pixel_scaler stage, one extra cycle of prefetch latency).
// Ports
//   clock, reset_n : sole clock, synchronous active-low reset
//   start          : single-cycle frame request, honoured only in IDLE
//   busy, done     : frame in progress / one-cycle frame-latched pulse
//   mem_addr/rd    : frame-buffer read port, data returns next cycle
//   mem_data       : frame-buffer read data
//   rz_data/enable : to encoder data/enable (data is bit-reversed pixel)
//   rz_ready       : from encoder ready
//   brightness     : global scale (LED_SEQ_BRIGHTNESS_EN only)
module led_frame_sequencer
    import led_frame_sequencer_pkg::*;
#(
    parameter int unsigned NUM_LEDS   = 64,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] rz_data,
    output logic                  rz_enable,
    input  logic                  rz_ready
`ifdef LED_SEQ_BRIGHTNESS_EN
    ,
    input  logic [7:0]            brightness
`endif
);

    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(NUM_LEDS - 1);
    localparam int unsigned           PAD_WIDTH  = MAX_DATA_WIDTH - DATA_WIDTH;

    seq_state_t            state;
    logic [ADDR_WIDTH-1:0] index;
    logic                  rd_pending;     // mem_data carries the requested word this cycle
    logic                  prefetch_valid; // word captured and still waiting for the encoder
    logic                  seen_low;       // DRAIN_LATCH: encoder ready has dropped
    logic                  pix_arrive;     // word becomes available this cycle
    logic [DATA_WIDTH-1:0] pix_word;

    assign mem_addr = index;

`ifdef LED_SEQ_BRIGHTNESS_EN
    // The scaler's output register doubles as the prefetch register.
    pixel_scaler #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_pixel_scaler (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (rd_pending),
        .pixel      (mem_data),
        .brightness (brightness),
        .scaled     (pix_word),
        .valid      (pix_arrive)
    );
`else
    logic [DATA_WIDTH-1:0] prefetch;

    // Bypass the prefetch register on the arrival cycle so a ready encoder
    // gets its first pixel in cycle 3 after start.
    assign pix_arrive = rd_pending;
    assign pix_word   = rd_pending ? mem_data : prefetch;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prefetch <= '0;
        end else if (rd_pending) begin
            prefetch <= mem_data;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state          <= IDLE;
            index          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mem_rd         <= 1'b0;
            rz_enable      <= 1'b0;
            rz_data        <= '0;
            rd_pending     <= 1'b0;
            prefetch_valid <= 1'b0;
            seen_low       <= 1'b0;
        end else begin
            mem_rd     <= 1'b0;
            rz_enable  <= 1'b0;
            done       <= 1'b0;
            rd_pending <= mem_rd;
            if (pix_arrive) begin
                prefetch_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        index  <= '0;
                        mem_rd <= 1'b1;
                        busy   <= 1'b1;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (rz_ready && (pix_arrive || prefetch_valid)) begin
                        rz_enable      <= 1'b1;
                        // Left-align then mirror: encoder shifts LSB first, pixel MSB leads.
                        rz_data        <= DATA_WIDTH'(bit_reverse(MAX_DATA_WIDTH'(pix_word) << PAD_WIDTH));
                        prefetch_valid <= 1'b0;
                        state          <= SEND;
                    end
                end
                SEND: begin
                    if (index != LAST_INDEX) begin
                        index  <= index + ADDR_WIDTH'(1);
                        mem_rd <= 1'b1;
                        state  <= FETCH;
                    end else begin
                        state <= DRAIN_HANDOVER;
                    end
                end
                DRAIN_HANDOVER: begin
                    // Withholding enable after this ready sends the encoder into its latch interval.
                    if (rz_ready) begin
                        seen_low <= 1'b0;
                        state    <= DRAIN_LATCH;
                    end
                end
                DRAIN_LATCH: begin
                    // done is raised while still out of IDLE, so a start in the done cycle is dropped.
                    if (done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (!seen_low) begin
                        if (!rz_ready) begin
                            seen_low <= 1'b1;
                        end
                    end else if (rz_ready) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
